gpio_port_ctrl: RTL and testbench
=================================

// Module: gpio_port_ctrl
// PURPOSE
//  Parametrised GPIO port controller between off-chip GPIO pins and the core register file.
//  Input path: synchronises the pin-side valid and detects its rising edge. It captures the
//  pin data word and buffers it in an RX FIFO with a ready/valid read interface.
//  Output path: accepts words from the register file via ready/valid. It drives them on the
//  pins with a programmable setup gap and strobe length.
// PARAMETERS
//  WIDTH       8  data width of input and output GPIO words
//  SYNC_STAGES 2  synchroniser flops on in_gpio_valid (>=2)
//  FIFO_DEPTH  4  RX FIFO entries (power of 2, >=2)
//  SETUP_CYC   1  cycles out_gpio is stable before out_gpio_valid rises (>=1)
//  STROBE_CYC  2  cycles out_gpio_valid is held high (>=1)
// PORTS
//  i_clk           in   1                      clock; all flops on posedge
//  i_rstn          in   1                      reset, asynchronous, active-low
//  in_gpio_data    in   WIDTH                  pin data; stable while in_gpio_valid high
//  in_gpio_valid   in   1                      pin-side valid, asynchronous to i_clk
//  rx_data         out  WIDTH                  FIFO head word
//  rx_valid        out  1                      FIFO non-empty
//  rx_ready        in   1                      core pops head when rx_valid & rx_ready
//  rx_count        out  $clog2(FIFO_DEPTH)+1   current occupancy
//  rx_overflow     out  1                      sticky: capture dropped because FIFO full
//  clr_ovf         in   1                      clears rx_overflow
//  tx_data         in   WIDTH                  word to drive on pins
//  tx_valid        in   1                      tx request
//  tx_ready        out  1                      high only in IDLE
//  out_gpio        out  WIDTH                  pin output data; holds last word
//  out_gpio_valid  out  1                      pin output strobe
// BEHAVIOUR
//  Reset:
//  - All outputs are 0: rx_valid, rx_count, rx_overflow, out_gpio, out_gpio_valid, rx_data.
//  - tx_ready=1 after reset release. FIFO pointers are 0. TX FSM is IDLE.
//  - Reset mid-transfer aborts immediately. FIFO contents are discarded.
//  RX synchroniser:
//  - in_gpio_valid passes through SYNC_STAGES flops, followed by one prev flop.
//  - rise = sync_last & ~prev.
//  - A pin valid first sampled at edge N causes a push at edge N+SYNC_STAGES.
//  - rx_valid is visible after that edge.
//  - The push captures in_gpio_data directly at the push edge; data is protocol-stable.
//  - Level held high yields exactly one push. A new push needs valid low for >=1 synced cycle.
//  RX FIFO:
//  - Circular buffer. Pointers wrap modulo FIFO_DEPTH. rx_data = mem[rd_ptr] (show-ahead).
//  - Pop when rx_valid & rx_ready. rx_ready while empty is ignored.
//  - Push while full without simultaneous pop: word dropped, contents unchanged.
//    rx_overflow is set at the next edge.
//  - Push while full with simultaneous pop: both occur, count stays FIFO_DEPTH, no overflow.
//  - Push and pop while empty: push only (no bypass); count becomes 1.
//  - clr_ovf clears rx_overflow. If clr_ovf coincides with a new overflow, set wins.
//  TX FSM (IDLE -> SETUP -> STROBE -> IDLE):
//  - IDLE: tx_ready=1. On tx_valid: latch out_gpio=tx_data, load counter=SETUP_CYC-1, go SETUP.
//  - SETUP: out_gpio_valid=0. At counter 0, load counter=STROBE_CYC-1 and go STROBE.
//    Otherwise decrement.
//  - STROBE: out_gpio_valid=1. At counter 0, go IDLE. Otherwise decrement.
//  - tx_valid outside IDLE is ignored (tx_ready=0).
//  - Back-to-back words are separated by >=1 IDLE cycle.
//  - out_gpio changes only at acceptance.
//  - out_gpio_valid is registered: it rises SETUP_CYC cycles after acceptance
//    and is high for exactly STROBE_CYC cycles.
//  RX and TX paths are fully independent.
// TESTING
//  1. Reset: assert i_rstn=0 mid-strobe, mid-FIFO-fill -> all outputs 0, rx_count=0;
//     tx_ready=1 after release.
//  2. Single capture: data=0xA5, valid high for 5 cycles -> one push;
//     rx_valid at edge N+2; rx_data=0xA5; pop -> empty.
//  3. Fill and overflow: 5 pulses 0x01..0x05, no pops, DEPTH=4 -> rx_count=4,
//     rx_overflow=1, pops return 0x01..0x04; clr_ovf -> 0.
//  4. Full with push+pop same cycle: FIFO full, pop on push edge -> count stays 4,
//     no overflow, order preserved with wrap.
//  5. TX: tx_data=0x3C accepted at cycle 0 (SETUP=1, STROBE=2) -> out_gpio=0x3C from
//     cycle 1; valid high cycles 2-3; tx_ready low for 3 cycles.
//  6. TX ignore: tx_valid=1 held continuously with changing data -> only words
//     presented while tx_ready=1 are driven; strobes spaced by 1 idle cycle.

Source files
------------

// File: rtl/gpio_port_ctrl.sv
// GPIO port controller.
// RX: synchronise the asynchronous pin valid, push one word per rising edge into a
// show-ahead FIFO with a sticky overflow flag.
// TX: ready/valid word acceptance, then drive the pins with a setup gap followed by a
// strobe of fixed length. The RX and TX paths share nothing but clock and reset.
module gpio_port_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic [WIDTH-1:0]              in_gpio_data,
    input  logic                          in_gpio_valid,
    output logic [WIDTH-1:0]              rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          rx_overflow,
    input  logic                          clr_ovf,
    input  logic [WIDTH-1:0]              tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [WIDTH-1:0]              out_gpio,
    output logic                          out_gpio_valid
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int MAXC = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    // ---------------- RX synchroniser ----------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;

    // Shift the pin valid through the synchroniser and keep one delayed copy for edge detect.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_gpio_valid};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    // ---------------- RX FIFO ----------------
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             full, pop, push, drop;

    assign full = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign pop  = rx_valid & rx_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push = rise & (~full | pop);
    assign drop = rise & full & ~pop;

    // Occupancy and sticky overflow next-state; a new overflow beats a clear.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
        else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
        ovf_d = ovf_q;
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    // FIFO storage, pointers and flags; reset clears storage so rx_data reads 0.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_gpio_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign rx_valid    = (cnt_q != '0);
    assign rx_data     = mem_q[rd_ptr_q];
    assign rx_count    = cnt_q;
    assign rx_overflow = ovf_q;

    // ---------------- TX FSM ----------------
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE} tx_state_t;

    tx_state_t        state_q, state_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ovalid_q, ovalid_d;

    // Next-state: accept in IDLE, count down the setup gap, then the strobe.
    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        out_d    = out_q;
        tx_ready = (state_q == S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    out_d   = tx_data;
                    tcnt_d  = TW'(SETUP_CYC - 1);
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (tcnt_q == '0) begin
                    tcnt_d  = TW'(STROBE_CYC - 1);
                    state_d = S_STROBE;
                end else begin
                    tcnt_d = tcnt_q - TW'(1);
                end
            end
            S_STROBE: begin
                if (tcnt_q == '0) state_d = S_IDLE;
                else              tcnt_d  = tcnt_q - TW'(1);
            end
            default: state_d = S_IDLE;
        endcase
        // Registered strobe tracks the STROBE state exactly.
        ovalid_d = (state_d == S_STROBE);
    end

    // TX state, counter, pin data and strobe registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= S_IDLE;
            tcnt_q   <= '0;
            out_q    <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            out_q    <= out_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign out_gpio       = out_q;
    assign out_gpio_valid = ovalid_q;

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Bench for gpio_port_ctrl: directed scenarios followed by random traffic, checked
// against a cycle-level reference model and scoreboard queues.
module tb_gpio_port_ctrl;
    localparam int W  = 8;
    localparam int S  = 2;
    localparam int D  = 4;
    localparam int SU = 1;
    localparam int ST = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [W-1:0]  in_gpio_data = '0;
    logic          in_gpio_valid = 1'b0;
    logic [W-1:0]  rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic [2:0]    rx_count;
    logic          rx_overflow;
    logic          clr_ovf = 1'b0;
    logic [W-1:0]  tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [W-1:0]  out_gpio;
    logic          out_gpio_valid;

    gpio_port_ctrl #(.WIDTH(W), .SYNC_STAGES(S), .FIFO_DEPTH(D), .SETUP_CYC(SU), .STROBE_CYC(ST)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .in_gpio_data(in_gpio_data), .in_gpio_valid(in_gpio_valid),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_count(rx_count), .rx_overflow(rx_overflow), .clr_ovf(clr_ovf),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .out_gpio(out_gpio), .out_gpio_valid(out_gpio_valid)
    );

    initial forever #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Pin valid samples taken at each edge since reset; a push happens S edges after a
    // sample that was high while the sample before it was low.
    bit           samp[$];
    logic [W-1:0] mq[$];     // expected FIFO contents, head first
    bit           movf = 1'b0;
    longint       ecnt = 0, free_at = 0, vstart = 1, vend = 0;
    logic [W-1:0] mout = '0;
    logic [W-1:0] txq[$];    // words accepted, awaiting their strobe
    bit           m_rise, m_pop, m_ovf_set, m_acc;
    int           m_n;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            samp.delete(); mq.delete(); txq.delete();
            movf = 1'b0; ecnt = 0; free_at = 0; vstart = 1; vend = 0; mout = '0;
        end else begin
            m_n    = samp.size();
            m_rise = (m_n >= S && samp[m_n-S]) && !(m_n >= S+1 && samp[m_n-S-1]);
            samp.push_back(in_gpio_valid);
            m_pop     = (mq.size() > 0) && rx_ready;
            m_ovf_set = 1'b0;
            if (m_pop) void'(mq.pop_front());
            if (m_rise) begin
                if (mq.size() < D) mq.push_back(in_gpio_data);
                else               m_ovf_set = 1'b1;
            end
            if (m_ovf_set)    movf = 1'b1;
            else if (clr_ovf) movf = 1'b0;
            m_acc = (ecnt >= free_at) && tx_valid;
            ecnt++;
            if (m_acc) begin
                mout = tx_data;
                txq.push_back(tx_data);
                vstart  = ecnt + SU;
                vend    = ecnt + SU + ST - 1;
                free_at = ecnt + SU + ST;
            end
        end
    end

    // ---------------- monitor ----------------
    bit prev_ov = 1'b0;
    logic [W-1:0] exp_w;

    always @(negedge clk) begin
        if (!rstn) begin
            chk("rst_rx_valid",  32'(rx_valid), 32'd0);
            chk("rst_rx_count",  32'(rx_count), 32'd0);
            chk("rst_rx_ovf",    32'(rx_overflow), 32'd0);
            chk("rst_rx_data",   32'(rx_data), 32'd0);
            chk("rst_out_gpio",  32'(out_gpio), 32'd0);
            chk("rst_out_valid", 32'(out_gpio_valid), 32'd0);
            prev_ov = 1'b0;
        end else begin
            chk("rx_valid", 32'(rx_valid), 32'(mq.size() > 0));
            chk("rx_count", 32'(rx_count), 32'(mq.size()));
            chk("rx_overflow", 32'(rx_overflow), 32'(movf));
            if (mq.size() > 0) chk("rx_data", 32'(rx_data), 32'(mq[0]));
            chk("tx_ready", 32'(tx_ready), 32'(ecnt >= free_at));
            chk("out_gpio_valid", 32'(out_gpio_valid), 32'(ecnt >= vstart && ecnt <= vend));
            chk("out_gpio", 32'(out_gpio), 32'(mout));
            if (out_gpio_valid && !prev_ov) begin
                if (txq.size() == 0) begin
                    n_total++;
                    $display("FAIL tx_strobe: got strobe with data %0h expected no strobe", out_gpio);
                end else begin
                    exp_w = txq.pop_front();
                    chk("tx_strobe_data", 32'(out_gpio), 32'(exp_w));
                end
            end
            prev_ov = out_gpio_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [W-1:0] d, input int hi);
        in_gpio_data  = d;
        in_gpio_valid = 1'b1;
        cyc(hi);
        in_gpio_valid = 1'b0;
        cyc(2);
    endtask

    initial begin
        cyc(3);
        rstn = 1'b1;
        cyc(2);

        // single capture, held high for several cycles
        pulse(8'hA5, 5);
        cyc(2);
        rx_ready = 1'b1; cyc(2); rx_ready = 1'b0;

        // fill and overflow, then clear
        for (int i = 1; i <= 5; i++) pulse(W'(i), 1);
        cyc(3);
        clr_ovf = 1'b1; cyc(1); clr_ovf = 1'b0;
        rx_ready = 1'b1; cyc(6); rx_ready = 1'b0;

        // full FIFO with pop on the push edge
        for (int i = 0; i < 4; i++) pulse(8'h10 + W'(i), 1);
        in_gpio_data = 8'h20; in_gpio_valid = 1'b1; cyc(1);
        in_gpio_valid = 1'b0; cyc(S-1);
        rx_ready = 1'b1; cyc(1); rx_ready = 1'b0;
        cyc(2);
        rx_ready = 1'b1; cyc(6); rx_ready = 1'b0;

        // single TX word
        tx_data = 8'h3C; tx_valid = 1'b1; cyc(1); tx_valid = 1'b0; cyc(5);

        // TX valid held with changing data
        tx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tx_data = W'($urandom);
            cyc(1);
        end
        tx_valid = 1'b0; cyc(4);

        // reset mid-fill and mid-strobe
        for (int i = 0; i < 3; i++) pulse(8'h60 + W'(i), 1);
        tx_data = 8'h55; tx_valid = 1'b1; cyc(1); tx_valid = 1'b0; cyc(1);
        rstn = 1'b0; cyc(2); rstn = 1'b1; cyc(3);

        // random traffic on both paths
        for (int i = 0; i < 2500; i++) begin
            rx_ready = ($urandom % 4 == 0);
            clr_ovf  = ($urandom % 16 == 0);
            tx_valid = $urandom % 2;
            tx_data  = W'($urandom);
            if ($urandom % 3 == 0) begin
                in_gpio_valid = ~in_gpio_valid;
                if (in_gpio_valid) in_gpio_data = W'($urandom);
            end
            if (i == 1200) rstn = 1'b0;
            if (i == 1202) rstn = 1'b1;
            cyc(1);
        end
        rx_ready = 1'b0; tx_valid = 1'b0; in_gpio_valid = 1'b0; clr_ovf = 1'b0;
        cyc(8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
